// File: rtl/centroid_extractor_if.sv
// Result-record stream from centroid_extractor: one record per surviving object,
// valid/ready handshake with data held stable while stalled.
interface centroid_extractor_if #(
    parameter int WORD_SIZE = 8,
    parameter int LOC_SIZE  = 16
);
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] out_label;
    logic [LOC_SIZE-1:0]  out_cx;
    logic [LOC_SIZE-1:0]  out_cy;
    logic [LOC_SIZE-1:0]  out_area;

    modport master (
        output out_valid, out_label, out_cx, out_cy, out_area,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_label, out_cx, out_cy, out_area,
        output out_ready
    );
endinterface

// File: rtl/centroid_extractor.sv
// Walks labels 1..num_labels-1 of the labeling data table, computes integer
// centroids by serial restoring division and streams records for large-enough objects.
module centroid_extractor #(
    parameter int WORD_SIZE = 8,
    parameter int LOC_SIZE  = 16,
    parameter int MIN_AREA  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] num_labels,
    output logic [WORD_SIZE-1:0] obj_id,
    input  logic [LOC_SIZE-1:0]  obj_area,
    input  logic [LOC_SIZE-1:0]  obj_x,
    input  logic [LOC_SIZE-1:0]  obj_y,
    centroid_extractor_if.master res,
    output logic                 busy,
    output logic                 done
);
    localparam int REM_W = LOC_SIZE + 1;
    localparam int CNT_W = (LOC_SIZE > 1) ? $clog2(LOC_SIZE) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_CAPT, S_DIV, S_OUT, S_NEXT, S_FIN
    } state_t;

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] cur, last_q;
    logic [LOC_SIZE-1:0]  area_q, quo_x, quo_y, quo_x_d, quo_y_d;
    logic [REM_W-1:0]     rem_x, rem_y, rem_x_d, rem_y_d;
    logic [REM_W-1:0]     sh_x, sh_y, divisor;
    logic [CNT_W-1:0]     div_cnt;
    logic                 ge_x, ge_y, skip, div_last, scan_last;

    assign skip      = (obj_area == '0) || (obj_area < LOC_SIZE'(MIN_AREA));
    assign div_last  = (div_cnt == CNT_W'(LOC_SIZE - 1));
    assign scan_last = (cur == last_q - WORD_SIZE'(1));

    // One restoring-division step for x and y against the shared area divisor.
    always_comb begin
        divisor = {1'b0, area_q};
        sh_x    = (rem_x << 1) | REM_W'(quo_x[LOC_SIZE-1]);
        sh_y    = (rem_y << 1) | REM_W'(quo_y[LOC_SIZE-1]);
        ge_x    = (sh_x >= divisor);
        ge_y    = (sh_y >= divisor);
        rem_x_d = ge_x ? sh_x - divisor : sh_x;
        rem_y_d = ge_y ? sh_y - divisor : sh_y;
        quo_x_d = {quo_x[LOC_SIZE-2:0], ge_x};
        quo_y_d = {quo_y[LOC_SIZE-2:0], ge_y};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (num_labels > WORD_SIZE'(1)) ? S_FETCH : S_FIN;
            S_FETCH: state_d = S_CAPT;
            S_CAPT:  state_d = skip ? S_NEXT : S_DIV;
            S_DIV:   if (div_last) state_d = S_OUT;
            S_OUT:   if (res.out_ready) state_d = S_NEXT;
            S_NEXT:  state_d = scan_last ? S_FIN : S_FETCH;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign res.out_valid = (state_q == S_OUT);
    assign done          = (state_q == S_FIN);

    // obj_id is loaded on entry to FETCH so the table answers during CAPT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            obj_id        <= '0;
            cur           <= '0;
            last_q        <= '0;
            busy          <= 1'b0;
            area_q        <= '0;
            quo_x         <= '0;
            quo_y         <= '0;
            rem_x         <= '0;
            rem_y         <= '0;
            div_cnt       <= '0;
            res.out_label <= '0;
            res.out_cx    <= '0;
            res.out_cy    <= '0;
            res.out_area  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    last_q <= num_labels;
                    cur    <= WORD_SIZE'(1);
                    busy   <= 1'b1;
                    if (num_labels > WORD_SIZE'(1)) obj_id <= WORD_SIZE'(1);
                end
                S_CAPT: begin
                    area_q  <= obj_area;
                    quo_x   <= obj_x;
                    quo_y   <= obj_y;
                    rem_x   <= '0;
                    rem_y   <= '0;
                    div_cnt <= '0;
                end
                S_DIV: begin
                    quo_x   <= quo_x_d;
                    quo_y   <= quo_y_d;
                    rem_x   <= rem_x_d;
                    rem_y   <= rem_y_d;
                    div_cnt <= div_cnt + CNT_W'(1);
                    if (div_last) begin
                        res.out_label <= cur;
                        res.out_cx    <= quo_x_d;
                        res.out_cy    <= quo_y_d;
                        res.out_area  <= area_q;
                    end
                end
                S_NEXT: if (!scan_last) begin
                    cur    <= cur + WORD_SIZE'(1);
                    obj_id <= cur + WORD_SIZE'(1);
                end
                S_FIN: busy <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_centroid_extractor.sv
// Randomized scoreboard bench for centroid_extractor: a label-table model feeds the
// DUT, expected records are queued per scan and a monitor checks each handshake.
module tb_centroid_extractor;
    localparam int WS = 8;
    localparam int LS = 16;
    localparam int MA = 4;

    typedef struct packed {
        logic [WS-1:0] label;
        logic [LS-1:0] cx;
        logic [LS-1:0] cy;
        logic [LS-1:0] area;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [WS-1:0] num_labels;
    logic [WS-1:0] obj_id;
    logic [LS-1:0] obj_area, obj_x, obj_y;
    logic          busy, done;

    logic [LS-1:0] area_t [256];
    logic [LS-1:0] x_t    [256];
    logic [LS-1:0] y_t    [256];

    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    bit   ready_rand = 0;

    centroid_extractor_if #(.WORD_SIZE(WS), .LOC_SIZE(LS)) res_if ();

    centroid_extractor #(.WORD_SIZE(WS), .LOC_SIZE(LS), .MIN_AREA(MA)) dut (
        .clk        (clk),
        .reset      (rst),
        .start      (start),
        .num_labels (num_labels),
        .obj_id     (obj_id),
        .obj_area   (obj_area),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .res        (res_if),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Data table with one cycle of read latency.
    always @(posedge clk) begin
        obj_area <= area_t[obj_id];
        obj_x    <= x_t[obj_id];
        obj_y    <= y_t[obj_id];
    end

    function automatic rec_t cur_rec();
        return {res_if.out_label, res_if.out_cx, res_if.out_cy, res_if.out_area};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic clear_table();
        for (int i = 0; i < 256; i++) begin
            area_t[i] = '0; x_t[i] = '0; y_t[i] = '0;
        end
    endtask

    task automatic rand_table();
        for (int i = 0; i < 256; i++) begin
            case ($urandom_range(0, 3))
                0:       area_t[i] = '0;
                1:       area_t[i] = 16'($urandom_range(1, MA - 1));
                2:       area_t[i] = 16'($urandom_range(MA, 40));
                default: area_t[i] = 16'($urandom_range(MA, 65535));
            endcase
            x_t[i] = 16'($urandom_range(0, 65535));
            y_t[i] = 16'($urandom_range(0, 65535));
        end
    endtask

    // Reference: every label 1..n-1 with nonzero area >= MIN_AREA yields floor centroids.
    task automatic model_push(input int n);
        rec_t r;
        int a, xs, ys;
        for (int l = 1; l < n; l++) begin
            a  = int'(area_t[l]);
            xs = int'(x_t[l]);
            ys = int'(y_t[l]);
            if (a != 0 && a >= MA) begin
                r.label = 8'(l);
                r.cx    = 16'(xs / a);
                r.cy    = 16'(ys / a);
                r.area  = 16'(a);
                exp_q.push_back(r);
            end
        end
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk); #1 start = 1'b1; num_labels = 8'(n);
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit got = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin got = 1; break; end
        end
        chk("done_seen", 64'(got), 1);
    endtask

    // Index 0 is the cycle right after the edge that samples start.
    task automatic run_scan(input int n, input bit bursts,
                            output int f_idx, output int v_idx, output int h_idx,
                            output int d_idx, output int busy_cnt);
        int d0, budget;
        bit got;
        model_push(n);
        d0 = done_cnt; got = 0; busy_cnt = 0;
        f_idx = -1; v_idx = -1; h_idx = -1; d_idx = -1;
        budget = ((n < 2) ? 1 : n) * 200 + 50;
        @(posedge clk); #1 start = 1'b1; num_labels = 8'(n);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1 start = 1'b0;
            if (bursts && (i % 23 == 7)) begin
                start = 1'b1;
                num_labels = 8'($urandom_range(0, 255));
            end
            @(negedge clk);
            if (busy) busy_cnt++;
            if (f_idx < 0 && obj_id == 8'd1) f_idx = i;
            if (v_idx < 0 && res_if.out_valid) v_idx = i;
            if (h_idx < 0 && res_if.out_valid && res_if.out_ready) h_idx = i;
            if (done) begin d_idx = i; got = 1; break; end
        end
        start = 1'b0;
        chk("done_within_budget", 64'(got), 1);
        repeat (3) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        chk("done_count_per_start", 64'(done_cnt - d0), 1);
        chk("queue_drained", 64'(exp_q.size()), 0);
        chk("busy_low_after_done", 64'(busy), 0);
    endtask

    initial begin
        int f, v, h, d, b, id0;
        bit seen;
        rec_t snap;

        rst = 1'b1; start = 1'b0; num_labels = '0; res_if.out_ready = 1'b0;
        clear_table();

        fork
            begin : monitor
                bit   stall = 0, prev_done = 0;
                rec_t stall_rec, e;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        stall = 0; prev_done = 0;
                    end else begin
                        if (stall) begin
                            chk("stall_valid_held", 64'(res_if.out_valid), 1);
                            chk("stall_data_held", 64'(cur_rec()), 64'(stall_rec));
                        end
                        if (res_if.out_valid && res_if.out_ready) begin
                            if (exp_q.size() == 0) begin
                                checks++; errors++;
                                $display("FAIL extra_record actual label=%0d required none",
                                         res_if.out_label);
                            end else begin
                                e = exp_q.pop_front();
                                chk("record", 64'(cur_rec()), 64'(e));
                            end
                        end
                        if (prev_done) chk("done_single_cycle", 64'(done), 0);
                        stall     = res_if.out_valid && !res_if.out_ready;
                        stall_rec = cur_rec();
                        prev_done = done;
                        if (done) done_cnt++;
                    end
                end
            end
            begin : ready_driver
                forever begin
                    @(posedge clk); #1;
                    if (ready_rand) res_if.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_obj_id", 64'(obj_id), 0);
        chk("rst_out_valid", 64'(res_if.out_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_out_data", 64'(cur_rec()), 0);
        rst = 1'b0;

        // Single object: latency and done timing
        area_t[1] = 16'd10; x_t[1] = 16'd250; y_t[1] = 16'd73;
        res_if.out_ready = 1'b1;
        run_scan(2, 0, f, v, h, d, b);
        chk("t1_fetch_first_cycle", 64'(f), 0);
        chk("t1_valid_latency", 64'(v - f + 1), LS + 3);
        chk("t1_done_after_handshake", 64'(d - h), 2);

        // Skipped labels (area below minimum and zero)
        clear_table();
        area_t[1] = 16'd3; x_t[1] = 16'd30; y_t[1] = 16'd6;
        area_t[2] = 16'd0;
        area_t[3] = 16'd5; x_t[3] = 16'd12; y_t[3] = 16'd9;
        run_scan(4, 0, f, v, h, d, b);

        // Empty scans
        run_scan(1, 0, f, v, h, d, b);
        chk("t3_no_valid", 64'(v < 0), 1);
        chk("t3_done_next_cycle", 64'(d), 0);
        chk("t3_busy_le_1", 64'(b <= 1), 1);
        run_scan(0, 0, f, v, h, d, b);
        chk("t3_n0_done_next_cycle", 64'(d), 0);

        // Backpressure
        clear_table();
        area_t[1] = 16'd9; x_t[1] = 16'd1000; y_t[1] = 16'd77;
        model_push(2);
        res_if.out_ready = 1'b0;
        pulse_start(2);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (res_if.out_valid) begin seen = 1; break; end
        end
        chk("t4_valid_seen", 64'(seen), 1);
        snap = cur_rec();
        id0  = int'(obj_id);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("t4_hold_valid", 64'(res_if.out_valid), 1);
            chk("t4_hold_data", 64'(cur_rec()), 64'(snap));
            chk("t4_hold_obj_id", 64'(obj_id), 64'(id0));
        end
        @(posedge clk); #1 res_if.out_ready = 1'b1;
        @(negedge clk);
        chk("t4_accept_first_ready", 64'(res_if.out_valid && res_if.out_ready), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_valid_drops", 64'(res_if.out_valid), 0);
        wait_done(50);
        chk("t4_queue_drained", 64'(exp_q.size()), 0);

        // Reset in the middle of division
        rand_table();
        area_t[1] = 16'd7; x_t[1] = 16'd700; y_t[1] = 16'd50;
        pulse_start(3);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_obj_id", 64'(obj_id), 0);
        chk("t5_rst_valid", 64'(res_if.out_valid), 0);
        chk("t5_rst_busy", 64'(busy), 0);
        chk("t5_rst_done", 64'(done), 0);
        chk("t5_rst_data", 64'(cur_rec()), 0);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        run_scan(3, 0, f, v, h, d, b);

        // Repeated start while busy
        rand_table();
        ready_rand = 1;
        run_scan(6, 1, f, v, h, d, b);

        // Random scans with random backpressure
        for (int s = 0; s < 8; s++) begin
            rand_table();
            run_scan($urandom_range(0, 20), s[0], f, v, h, d, b);
        end

        // Saturated label count
        rand_table();
        run_scan(255, 0, f, v, h, d, b);
        chk("sat_last_obj_id", 64'(obj_id), 254);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
